mul_seq_ctrl: RTL and testbench

- Sequencer for a shared 33-bit-result adder (A + B + C0 → S[32:0]) that turns it into an unsigned WIDTH×WIDTH → 2·WIDTH shift-add multiplier.
- Holds the multiplicand, partial product and iteration counter, and drives the adder operands each cycle.
- Sits beside the ALU adder in the multi-cycle datapath. The CPU/top launches a multiply with start, waits on busy, and reads product when done pulses.

---
 rtl/mul_seq_ctrl.sv | 106 ++++++++++
 tb/tb_mul_seq_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Shift-add sequencer that turns a shared WIDTH+1-bit adder into an unsigned WIDTH x WIDTH multiplier.
// Optional zero-operand fast path: define MUL_ZERO_SKIP_EN.
//
// state  | meaning
// S_IDLE | waiting for start; operands latched on accept
// S_CALC | one shift-add iteration per cycle, WIDTH iterations
// S_DONE | product valid, one-cycle done pulse
module mul_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_c0,
  input  logic [WIDTH:0]     add_s
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_p_hi;
  logic [WIDTH-1:0]     r_p_lo;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_last;

  assign w_last  = (r_cnt == CNT_W'(WIDTH-1));
  assign add_a   = r_p_hi;
  assign add_b   = r_p_lo[0] ? r_a : '0;
  assign add_c0  = 1'b0;
  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_p_hi    <= '0;
      r_p_lo    <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a    <= a;
            r_p_lo <= b;
            r_p_hi <= '0;
            r_cnt  <= '0;
`ifdef MUL_ZERO_SKIP_EN
            if ((a == '0) || (b == '0)) begin
              r_product <= '0;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
`else
            r_busy  <= 1'b1;
            r_state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          // adder carry lands in the MSB of the shifted partial product
          r_p_hi <= add_s[WIDTH:1];
          r_p_lo <= {add_s[0], r_p_lo[WIDTH-1:1]};
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_product <= {add_s, r_p_lo[WIDTH-1:1]};
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl; the bench supplies the shared adder itself.
module tb_mul_seq_ctrl;
  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_c0;
  logic [W:0]     add_s;

  int total;
  int bad;

  mul_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_c0(add_c0), .add_s(add_s)
  );

  assign add_s = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one multiply and watch it; index 0 is the cycle right after the accepting edge.
  task automatic do_mul(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output logic [2*W-1:0] prod, output int lat,
                        output int ndone, output int nbusy, output bit ovl);
    prod = '0; lat = -1; ndone = 0; nbusy = 0; ovl = 0;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678;
    for (int i = 0; i < W + 8; i++) begin
      if (busy && done) ovl = 1;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat  = i;
          prod = product;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #3;
    total++;
    if ({busy, done, product, add_a, add_b, add_c0} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b product=%h add_a=%h add_b=%h add_c0=%b expected all 0",
               busy, done, product, add_a, add_b, add_c0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [2*W-1:0] p; int lat, nd, nb; bit ovl;
    do_mul(32'd3, 32'd5, p, lat, nd, nb, ovl);
    total++; if (p !== 64'd15) begin bad++; $display("FAIL basic_product got %h expected %h", p, 64'd15); end
    total++; if (lat !== W) begin bad++; $display("FAIL basic_latency got %0d expected %0d", lat, W); end
    total++; if (nd !== 1) begin bad++; $display("FAIL basic_done_count got %0d expected 1", nd); end
    total++; if (nb !== W) begin bad++; $display("FAIL basic_busy_cycles got %0d expected %0d", nb, W); end
    total++; if (ovl !== 1'b0) begin bad++; $display("FAIL basic_busy_done_overlap got %b expected 0", ovl); end
    total++; if (product !== 64'd15) begin bad++; $display("FAIL basic_product_hold got %h expected %h", product, 64'd15); end
  endtask

  task automatic test_carry();
    logic [2*W-1:0] p; int lat, nd, nb; bit ovl;
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, p, lat, nd, nb, ovl);
    total++; if (p !== 64'hFFFFFFFE00000001) begin bad++; $display("FAIL carry_product got %h expected %h", p, 64'hFFFFFFFE00000001); end
    total++; if (nd !== 1) begin bad++; $display("FAIL carry_done_count got %0d expected 1", nd); end
    do_mul(32'h80000001, 32'h00000003, p, lat, nd, nb, ovl);
    total++; if (p !== 64'h0000000180000003) begin bad++; $display("FAIL mixed_product got %h expected %h", p, 64'h0000000180000003); end
  endtask

  task automatic test_start_busy();
    bit found; int lat;
    @(negedge clk);
    a = 32'd7; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    repeat (10) @(negedge clk);
    total++; if (add_c0 !== 1'b0) begin bad++; $display("FAIL calc_c0 got %b expected 0", add_c0); end
    start = 1'b1; a = 32'd2; b = 32'd2;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin found = 1; break; end
      @(negedge clk);
    end
    total++; if (!found) begin bad++; $display("FAIL sb_first_done got none expected one within 40 cycles"); end
    total++; if (product !== 64'd63) begin bad++; $display("FAIL sb_first_product got %h expected %h", product, 64'd63); end
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL sb_idle_gap got busy=%b done=%b expected 0 0", busy, done); end
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL sb_relaunch got busy=%b expected 1", busy); end
    start = 1'b0; a = 32'd5; b = 32'd5;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin lat = i; break; end
      @(negedge clk);
    end
    total++; if (lat !== W) begin bad++; $display("FAIL sb_second_latency got %0d expected %0d", lat, W); end
    total++; if (product !== 64'd4) begin bad++; $display("FAIL sb_second_product got %h expected %h", product, 64'd4); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [2*W-1:0] p; int lat, nd, nb; bit ovl; bit saw;
    @(negedge clk);
    a = 32'd100; b = 32'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, product, add_a, add_b, add_c0} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got busy=%b done=%b product=%h add_a=%h add_b=%h expected all 0",
               busy, done, product, add_a, add_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done || busy) saw = 1;
      @(negedge clk);
    end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL midreset_no_done got activity=%b expected 0", saw); end
    do_mul(32'd100, 32'd200, p, lat, nd, nb, ovl);
    total++; if (p !== 64'd20000) begin bad++; $display("FAIL midreset_rerun got %h expected %h", p, 64'd20000); end
  endtask

  task automatic test_zero();
    logic [2*W-1:0] p; int lat, nd, nb; bit ovl;
    do_mul(32'd0, 32'd7, p, lat, nd, nb, ovl);
    total++; if (p !== 64'd0) begin bad++; $display("FAIL zero_product got %h expected 0", p); end
    total++; if (nd !== 1) begin bad++; $display("FAIL zero_done_count got %0d expected 1", nd); end
`ifdef MUL_ZERO_SKIP_EN
    total++; if (lat !== 0) begin bad++; $display("FAIL zero_latency got %0d expected 0", lat); end
    total++; if (nb !== 0) begin bad++; $display("FAIL zero_busy_cycles got %0d expected 0", nb); end
`else
    total++; if (lat !== W) begin bad++; $display("FAIL zero_latency got %0d expected %0d", lat, W); end
    total++; if (nb !== W) begin bad++; $display("FAIL zero_busy_cycles got %0d expected %0d", nb, W); end
`endif
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_basic();
    test_carry();
    test_start_busy();
    test_reset_mid();
    test_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
